// File: rtl/jump_input_arbiter.sv
// jump_input_arbiter: synchronizes and debounces the raw jump button, turns each
// clean press into a single jump request gated by the jump window, buffers early
// presses for a bounded time, and enforces a cooldown after each acknowledge.
module jump_input_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BUFFER_CYCLES   = 8,
  parameter int unsigned COOLDOWN_CYCLES = 6
) (
  input  logic       proc_clk,
  input  logic       reset,
  input  logic       jump_btn,
  input  logic       can_jump,
  input  logic       jump_ack,
  output logic       jump_req,
  output logic       btn_clean,
  output logic [7:0] granted_count,
  output logic [7:0] dropped_count
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BUF_W = (BUFFER_CYCLES > 1)   ? $clog2(BUFFER_CYCLES)   : 1;
  localparam int unsigned CD_W  = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam int unsigned CNT_W = 8;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BUF_W-1:0] BUF_LAST = BUF_W'(BUFFER_CYCLES - 1);
  localparam logic [CD_W-1:0]  CD_LAST  = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(255);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REQ      = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               btn_clean_q, btn_clean_d;
  logic               btn_prev_q, btn_prev_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [BUF_W-1:0]   buf_cnt_q, buf_cnt_d;
  logic [CD_W-1:0]    cd_cnt_q, cd_cnt_d;
  logic               jump_req_q, jump_req_d;
  logic [CNT_W-1:0]   granted_q, granted_d;
  logic [CNT_W-1:0]   dropped_q, dropped_d;
  logic               press_c;
  logic               drop_c;

  // Two-flop synchronizer and debounce filter on the raw button.
  always_comb begin
    s1_d        = jump_btn;
    s2_d        = s1_q;
    btn_clean_d = btn_clean_q;
    db_cnt_d    = db_cnt_q;
    btn_prev_d  = btn_clean_q;
    if (s2_q == btn_clean_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      btn_clean_d = s2_q;
      db_cnt_d    = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Rising edge of the clean button is a press; releases produce nothing.
  assign press_c = btn_clean_q & ~btn_prev_q;

  // Request FSM: next state, timers and event counters.
  always_comb begin
    state_d   = state_q;
    buf_cnt_d = buf_cnt_q;
    cd_cnt_d  = cd_cnt_q;
    granted_d = granted_q;
    drop_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_c) begin
          if (can_jump) begin
            state_d = ST_REQ;
          end else begin
            state_d   = ST_WAIT;
            buf_cnt_d = '0;
          end
        end
      end
      ST_WAIT: begin
        if (can_jump) begin
          state_d = ST_REQ;
        end else if (buf_cnt_q == BUF_LAST) begin
          state_d = ST_IDLE;
          drop_c  = 1'b1;
        end else begin
          buf_cnt_d = buf_cnt_q + BUF_W'(1);
        end
      end
      ST_REQ: begin
        drop_c = press_c;
        if (jump_ack) begin
          state_d   = ST_COOLDOWN;
          cd_cnt_d  = '0;
          granted_d = granted_q + CNT_W'(1);
        end
      end
      ST_COOLDOWN: begin
        drop_c = press_c;
        if (cd_cnt_q == CD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cd_cnt_d = cd_cnt_q + CD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    jump_req_d = (state_d == ST_REQ);
    dropped_d  = (drop_c && (dropped_q != CNT_MAX)) ? dropped_q + CNT_W'(1) : dropped_q;
  end

  // State register with asynchronous reset.
  always_ff @(posedge proc_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      btn_clean_q <= 1'b0;
      btn_prev_q  <= 1'b0;
      db_cnt_q    <= '0;
      buf_cnt_q   <= '0;
      cd_cnt_q    <= '0;
      jump_req_q  <= 1'b0;
      granted_q   <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      btn_clean_q <= btn_clean_d;
      btn_prev_q  <= btn_prev_d;
      db_cnt_q    <= db_cnt_d;
      buf_cnt_q   <= buf_cnt_d;
      cd_cnt_q    <= cd_cnt_d;
      jump_req_q  <= jump_req_d;
      granted_q   <= granted_d;
      dropped_q   <= dropped_d;
    end
  end

  assign jump_req      = jump_req_q;
  assign btn_clean     = btn_clean_q;
  assign granted_count = granted_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_jump_input_arbiter.sv
// Bench for jump_input_arbiter: directed scenarios plus random traffic, checked
// every cycle against a timestamp-based behavioural model.
module tb_jump_input_arbiter;

  localparam int D = 4;
  localparam int B = 8;
  localparam int C = 6;

  localparam int M_IDLE = 0;
  localparam int M_WAIT = 1;
  localparam int M_REQ  = 2;
  localparam int M_COOL = 3;

  logic       proc_clk = 1'b0;
  logic       reset;
  logic       jump_btn;
  logic       can_jump;
  logic       jump_ack;
  logic       jump_req;
  logic       btn_clean;
  logic [7:0] granted_count;
  logic [7:0] dropped_count;

  int errors = 0;
  int checks = 0;

  jump_input_arbiter #(
    .DEBOUNCE_CYCLES(D),
    .BUFFER_CYCLES  (B),
    .COOLDOWN_CYCLES(C)
  ) dut (
    .proc_clk     (proc_clk),
    .reset        (reset),
    .jump_btn     (jump_btn),
    .can_jump     (can_jump),
    .jump_ack     (jump_ack),
    .jump_req     (jump_req),
    .btn_clean    (btn_clean),
    .granted_count(granted_count),
    .dropped_count(dropped_count)
  );

  always #5 proc_clk = ~proc_clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sample history, a mismatch streak for the debouncer,
  // and edge timestamps for the buffer and cooldown windows.
  int m_s1, m_s2, m_streak, m_mode, m_cyc, m_wait_start, m_cool_start;
  int m_granted, m_dropped;
  bit m_clean, m_prev, m_press, m_drop;

  always @(posedge proc_clk or posedge reset) begin
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_streak = 0; m_mode = M_IDLE; m_cyc = 0;
      m_wait_start = 0; m_cool_start = 0; m_granted = 0; m_dropped = 0;
      m_clean = 0; m_prev = 0;
    end else begin
      m_cyc++;
      m_press = m_clean && !m_prev;
      m_drop  = 0;
      case (m_mode)
        M_IDLE: if (m_press) begin
          if (can_jump) m_mode = M_REQ;
          else begin m_mode = M_WAIT; m_wait_start = m_cyc; end
        end
        M_WAIT: begin
          if (can_jump) m_mode = M_REQ;
          else if (m_cyc == m_wait_start + B) begin m_mode = M_IDLE; m_drop = 1; end
        end
        M_REQ: begin
          if (m_press) m_drop = 1;
          if (jump_ack) begin
            m_mode = M_COOL; m_cool_start = m_cyc;
            m_granted = (m_granted + 1) % 256;
          end
        end
        default: begin
          if (m_press) m_drop = 1;
          if (m_cyc == m_cool_start + C) m_mode = M_IDLE;
        end
      endcase
      if (m_drop && m_dropped < 255) m_dropped++;
      m_prev = m_clean;
      if (m_s2 != int'(m_clean)) begin
        m_streak++;
        if (m_streak == D) begin m_clean = (m_s2 != 0); m_streak = 0; end
      end else begin
        m_streak = 0;
      end
      m_s2 = m_s1;
      m_s1 = int'(jump_btn);
    end
    #1;
    check("jump_req", int'(jump_req), int'(m_mode == M_REQ));
    check("btn_clean", int'(btn_clean), int'(m_clean));
    check("granted_count", int'(granted_count), m_granted);
    check("dropped_count", int'(dropped_count), m_dropped);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge proc_clk);
      #2;
    end
  endtask

  task automatic wait_clean(input logic v);
    int n = 0;
    while (btn_clean !== v && n < 50) begin tick(); n++; end
    if (btn_clean !== v) check("wait_clean_timeout", int'(btn_clean), int'(v));
  endtask

  task automatic wait_req(input logic v);
    int n = 0;
    while (jump_req !== v && n < 50) begin tick(); n++; end
    if (jump_req !== v) check("wait_req_timeout", int'(jump_req), int'(v));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; jump_btn = 1'b0; can_jump = 1'b0; jump_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    check("rst_req", int'(jump_req), 0);
    check("rst_clean", int'(btn_clean), 0);
    check("rst_granted", int'(granted_count), 0);
    check("rst_dropped", int'(dropped_count), 0);

    // Best-case grant latency and acknowledge.
    jump_btn = 1'b1; can_jump = 1'b1;
    tick(5);
    check("lat_clean_e5", int'(btn_clean), 0);
    tick();
    check("lat_clean_e6", int'(btn_clean), 1);
    check("lat_req_e6", int'(jump_req), 0);
    tick();
    check("lat_req_e7", int'(jump_req), 1);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    check("ack_req_low", int'(jump_req), 0);
    check("ack_granted", int'(granted_count), 1);
    jump_btn = 1'b0; can_jump = 1'b0;
    tick(12);

    // Short glitches never reach btn_clean.
    jump_btn = 1'b1; tick(3); jump_btn = 1'b0; tick(6);
    jump_btn = 1'b1; tick(1); jump_btn = 1'b0; tick(6);
    check("glitch_clean", int'(btn_clean), 0);
    check("glitch_req", int'(jump_req), 0);
    check("glitch_dropped", int'(dropped_count), 0);

    // Buffered press granted when the window opens late.
    jump_btn = 1'b1;
    wait_clean(1'b1);
    tick(5);
    can_jump = 1'b1;
    tick();
    check("wait_grant_req", int'(jump_req), 1);
    check("wait_grant_drop", int'(dropped_count), 0);
    can_jump = 1'b0; jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0; jump_btn = 1'b0;
    tick(14);

    // Buffered press expires after the full window.
    jump_btn = 1'b1;
    wait_clean(1'b1);
    tick(8);
    check("wait_expire_before", int'(dropped_count), 0);
    tick();
    check("wait_expire_drop", int'(dropped_count), 1);
    check("wait_expire_req", int'(jump_req), 0);
    jump_btn = 1'b0;
    tick(8);

    // Presses during REQ and COOLDOWN are counted as dropped.
    do_reset();
    can_jump = 1'b1; jump_btn = 1'b1;
    wait_clean(1'b1);
    tick();
    check("req_held", int'(jump_req), 1);
    can_jump = 1'b0;
    for (int i = 0; i < 2; i++) begin
      jump_btn = 1'b0; wait_clean(1'b0);
      jump_btn = 1'b1; wait_clean(1'b1);
      tick();
    end
    check("req_still_high", int'(jump_req), 1);
    check("req_drops", int'(dropped_count), 2);
    jump_btn = 1'b0; wait_clean(1'b0);
    jump_btn = 1'b1;
    tick(4);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    check("cool_granted", int'(granted_count), 1);
    tick(2);
    check("cool_drop", int'(dropped_count), 3);
    jump_btn = 1'b0;
    tick(12);

    // Asynchronous reset while requesting, with the button held.
    can_jump = 1'b1; jump_btn = 1'b1;
    wait_clean(1'b1);
    tick();
    check("pre_reset_req", int'(jump_req), 1);
    reset = 1'b1;
    #1;
    check("async_rst_req", int'(jump_req), 0);
    check("async_rst_clean", int'(btn_clean), 0);
    check("async_rst_drop", int'(dropped_count), 0);
    tick(2);
    reset = 1'b0;
    tick(5);
    check("post_rst_clean_e5", int'(btn_clean), 0);
    tick();
    check("post_rst_clean_e6", int'(btn_clean), 1);
    tick();
    check("post_rst_req", int'(jump_req), 1);
    jump_ack = 1'b1; tick(); jump_ack = 1'b0;
    jump_btn = 1'b0; can_jump = 1'b0;
    tick(12);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) jump_btn = ~jump_btn;
      can_jump = ($urandom_range(0, 2) == 0);
      jump_ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    jump_btn = 1'b0; can_jump = 1'b0; jump_ack = 1'b0;
    tick(20);

    // Counter wrap and saturation.
    do_reset();
    for (int i = 0; i < 260; i++) begin
      jump_btn = 1'b1; can_jump = 1'b1;
      wait_req(1'b1);
      jump_ack = 1'b1; tick(); jump_ack = 1'b0;
      jump_btn = 1'b0; can_jump = 1'b0;
      wait_clean(1'b0);
      tick(2);
    end
    check("granted_wrap", int'(granted_count), 4);
    for (int i = 0; i < 300; i++) begin
      jump_btn = 1'b1;
      wait_clean(1'b1);
      jump_btn = 1'b0;
      tick(10);
    end
    check("dropped_sat", int'(dropped_count), 255);
    check("granted_final", int'(granted_count), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
